// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer slice:
// register offsets, default frame-step positions and sequence modes.
package apu_pkg;

  localparam int DEF_CNT_W = 16;

  localparam int unsigned DEF_STEP1 = 7457;
  localparam int unsigned DEF_STEP2 = 14913;
  localparam int unsigned DEF_STEP3 = 22371;
  localparam int unsigned DEF_STEP4 = 29829;
  localparam int unsigned DEF_STEP5 = 37281;

  localparam logic [4:0] ADDR_TRI0   = 5'h08;
  localparam logic [4:0] ADDR_TRI2   = 5'h0A;
  localparam logic [4:0] ADDR_TRI3   = 5'h0B;
  localparam logic [4:0] ADDR_STATUS = 5'h15;
  localparam logic [4:0] ADDR_FRAME  = 5'h17;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/apu_frame_divider.sv
// Free-running frame counter with mode-dependent wrap and
// step-match decode; a synchronous clear restarts the sequence.
module apu_frame_divider
  import apu_pkg::*;
#(
  parameter int          CNT_W = DEF_CNT_W,
  parameter int unsigned STEP1 = DEF_STEP1,
  parameter int unsigned STEP2 = DEF_STEP2,
  parameter int unsigned STEP3 = DEF_STEP3,
  parameter int unsigned STEP4 = DEF_STEP4,
  parameter int unsigned STEP5 = DEF_STEP5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  seq_mode_e mode,
  input  logic      clear,
  output logic      quarter_hit,
  output logic      half_hit,
  output logic      irq_hit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  always_comb begin
    last = CNT_W'(STEP4);
    if (mode == MODE_5STEP) last = CNT_W'(STEP5);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // STEP4 is silent in 5-step mode; STEP5 is never reached in 4-step
  always_comb begin
    quarter_hit = 1'b0;
    half_hit    = 1'b0;
    irq_hit     = 1'b0;
    unique case (1'b1)
      cnt == CNT_W'(STEP1): quarter_hit = 1'b1;
      cnt == CNT_W'(STEP2): begin
        quarter_hit = 1'b1;
        half_hit    = 1'b1;
      end
      cnt == CNT_W'(STEP3): quarter_hit = 1'b1;
      cnt == CNT_W'(STEP4): begin
        if (mode == MODE_4STEP) begin
          quarter_hit = 1'b1;
          half_hit    = 1'b1;
          irq_hit     = 1'b1;
        end
      end
      cnt == CNT_W'(STEP5): begin
        if (mode == MODE_5STEP) begin
          quarter_hit = 1'b1;
          half_hit    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// Triangle register writer and frame sequencer.
// Define APU_FRAME_IRQ_EN to build the frame IRQ set/clear logic.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int          CNT_W = DEF_CNT_W,
  parameter int unsigned STEP1 = DEF_STEP1,
  parameter int unsigned STEP2 = DEF_STEP2,
  parameter int unsigned STEP3 = DEF_STEP3,
  parameter int unsigned STEP4 = DEF_STEP4,
  parameter int unsigned STEP5 = DEF_STEP5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_we,
  input  logic       cpu_re,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] tri_reg0,
  output logic [7:0] tri_reg2,
  output logic [7:0] tri_reg3,
  output logic       tri_reload,
  output logic       quarter_clk,
  output logic       half_clk,
  output logic       frame_irq
);

  seq_mode_e mode;
  logic      inhibit;
  logic      quarter_hit;
  logic      half_hit;
  logic      irq_hit;
  logic      frame_wr;
  logic      now_pulse;

  assign frame_wr  = cpu_we && (cpu_addr == ADDR_FRAME);
  assign now_pulse = frame_wr && cpu_wdata[7];

  apu_frame_divider #(
    .CNT_W (CNT_W),
    .STEP1 (STEP1),
    .STEP2 (STEP2),
    .STEP3 (STEP3),
    .STEP4 (STEP4),
    .STEP5 (STEP5)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .clear       (frame_wr),
    .quarter_hit (quarter_hit),
    .half_hit    (half_hit),
    .irq_hit     (irq_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_reg0    <= '0;
      tri_reg2    <= '0;
      tri_reg3    <= '0;
      tri_reload  <= 1'b0;
      quarter_clk <= 1'b0;
      half_clk    <= 1'b0;
      mode        <= MODE_4STEP;
      inhibit     <= 1'b0;
    end else begin
      if (cpu_we) begin
        unique case (cpu_addr)
          ADDR_TRI0: tri_reg0 <= cpu_wdata;
          ADDR_TRI2: tri_reg2 <= cpu_wdata;
          ADDR_TRI3: tri_reg3 <= cpu_wdata;
          default: ;
        endcase
      end
      tri_reload  <= cpu_we && (cpu_addr == ADDR_TRI3);
      // match and immediate pulse merge into one cycle
      quarter_clk <= quarter_hit || now_pulse;
      half_clk    <= half_hit || now_pulse;
      if (frame_wr) begin
        mode    <= seq_mode_e'(cpu_wdata[7]);
        inhibit <= cpu_wdata[6];
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic irq_clr;

  assign irq_clr = (cpu_re && (cpu_addr == ADDR_STATUS))
                || (frame_wr && cpu_wdata[6]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_irq <= 1'b0;
    end else if (irq_hit && !inhibit) begin
      frame_irq <= 1'b1;
    end else if (irq_clr) begin
      frame_irq <= 1'b0;
    end
  end
`else
  logic irq_unused;

  assign irq_unused = ^{cpu_re, inhibit, irq_hit};
  assign frame_irq  = 1'b0;
`endif

endmodule
